// File: rtl/gate_pkg.sv
// Shared types and gate-function helper for the lamp-bank / gate-evaluation stage.
package gate_pkg;

  localparam int MAX_LAMP_N = 8;

  typedef enum logic [2:0] {
    GATE_AND  = 3'd0,
    GATE_OR   = 3'd1,
    GATE_NAND = 3'd2,
    GATE_NOR  = 3'd3,
    GATE_XOR  = 3'd4,
    GATE_XNOR = 3'd5
  } gate_e;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_FIRE   = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Only the low n bits of vec take part; constant-foldable for reset values.
  function automatic logic gate_eval(input gate_e gtype, input logic [MAX_LAMP_N-1:0] vec,
                                     input int n);
    logic [MAX_LAMP_N-1:0] mask;
    logic all1, any1, odd1, res;
    for (int i = 0; i < MAX_LAMP_N; i++) begin
      mask[i] = (i < n) ? 1'b1 : 1'b0;
    end
    all1 = &(vec | ~mask);
    any1 = |(vec & mask);
    odd1 = ^(vec & mask);
    case (gtype)
      GATE_AND:  res = all1;
      GATE_OR:   res = any1;
      GATE_NAND: res = ~all1;
      GATE_NOR:  res = ~any1;
      GATE_XOR:  res = odd1;
      GATE_XNOR: res = ~odd1;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_lamp_bank.sv
// Lamp toggle register: every set toggle bit flips its lamp once per cycle.
module gate_lamp_bank
  import gate_pkg::*;
#(
  parameter int                LAMP_N    = 4,
  parameter logic [LAMP_N-1:0] LAMP_INIT = {LAMP_N{1'b0}}
) (
  input  logic              clk,
  input  logic              logic_reset,
  input  logic [LAMP_N-1:0] toggle,
  output logic [LAMP_N-1:0] lamp_state
);

  // Lamp vector register
  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      lamp_state <= LAMP_INIT;
    end else begin
      lamp_state <= lamp_state ^ toggle;
    end
  end

endmodule

// File: rtl/gate_lamp_eval.sv
// Lamp bank plus gate evaluation with a once-per-step output pulse.
// Optional suppressed-change counter enabled by macro GATE_LAMP_MISS_CNT_EN.
module gate_lamp_eval
  import gate_pkg::*;
#(
  parameter int                LAMP_N    = 4,
  parameter int                GATE_TYPE = 0,
  parameter logic [LAMP_N-1:0] LAMP_INIT = {LAMP_N{1'b0}}
) (
  input  logic              clk,
  input  logic              logic_reset,
  input  logic              step_start,
  input  logic [LAMP_N-1:0] toggle,
  output logic [LAMP_N-1:0] lamp_state,
  output logic              gate_state,
  output logic              out,
  output logic              locked
`ifdef GATE_LAMP_MISS_CNT_EN
  ,
  output logic [7:0]        miss_cnt
`endif
);

  if (LAMP_N < 1 || LAMP_N > MAX_LAMP_N) begin : g_bad_lamp_n
    $error("gate_lamp_eval: LAMP_N must be 1..8");
  end
  if (GATE_TYPE < 0 || GATE_TYPE > 5) begin : g_bad_gate_type
    $error("gate_lamp_eval: GATE_TYPE must be 0..5");
  end

  localparam logic [2:0]            GT_BITS   = 3'(GATE_TYPE);
  localparam gate_e                 GTYPE     = gate_e'(GT_BITS);
  localparam logic [MAX_LAMP_N-1:0] INIT_EXT  = MAX_LAMP_N'(LAMP_INIT);
  // Reset gate result matches the reset lamps, so nothing fires out of reset.
  localparam logic                  GATE_INIT = gate_eval(GTYPE, INIT_EXT, LAMP_N);

  state_e                state_r, state_nxt_s;
  logic [MAX_LAMP_N-1:0] vec_s;
  logic                  eval_s, gate_nxt_s, out_nxt_s;

  gate_lamp_bank #(
    .LAMP_N   (LAMP_N),
    .LAMP_INIT(LAMP_INIT)
  ) u_bank (
    .clk        (clk),
    .logic_reset(logic_reset),
    .toggle     (toggle),
    .lamp_state (lamp_state)
  );

  // Gate function over the current lamps
  always_comb begin
    vec_s              = {MAX_LAMP_N{1'b0}};
    vec_s[LAMP_N-1:0]  = lamp_state;
    eval_s             = gate_eval(GTYPE, vec_s, LAMP_N);
  end

  // Fire/lock next-state; while disarmed the gate result tracks silently
  always_comb begin
    state_nxt_s = state_r;
    gate_nxt_s  = gate_state;
    out_nxt_s   = 1'b0;
    case (state_r)
      ST_ARMED: begin
        if (eval_s != gate_state) begin
          gate_nxt_s  = eval_s;
          out_nxt_s   = 1'b1;
          state_nxt_s = ST_FIRE;
        end else begin
          state_nxt_s = ST_ARMED;
        end
      end
      ST_FIRE, ST_LOCKED: begin
        gate_nxt_s = eval_s;
        if (step_start) begin
          state_nxt_s = ST_ARMED;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        gate_nxt_s  = eval_s;
        state_nxt_s = ST_ARMED;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      state_r    <= ST_ARMED;
      gate_state <= GATE_INIT;
      out        <= 1'b0;
      locked     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      gate_state <= gate_nxt_s;
      out        <= out_nxt_s;
      locked     <= (state_nxt_s != ST_ARMED) ? 1'b1 : 1'b0;
    end
  end

`ifdef GATE_LAMP_MISS_CNT_EN
  logic miss_evt_s;

  // A change seen while disarmed is a suppressed pulse
  always_comb begin
    miss_evt_s = 1'b0;
    if (state_r != ST_ARMED) begin
      miss_evt_s = (eval_s != gate_state) ? 1'b1 : 1'b0;
    end else begin
      miss_evt_s = 1'b0;
    end
  end

  // Saturating suppressed-change counter
  always_ff @(posedge clk or posedge logic_reset) begin
    if (logic_reset) begin
      miss_cnt <= 8'd0;
    end else if (miss_evt_s && (miss_cnt != 8'hFF)) begin
      miss_cnt <= miss_cnt + 8'd1;
    end else begin
      miss_cnt <= miss_cnt;
    end
  end
`endif

endmodule

// File: doc/gate_lamp_eval.md
# gate_lamp_eval

Lamp-bank and gate-evaluation stage of the wiring logic simulator. It holds the toggle state of up to 8 lamps stacked on one logic gate and evaluates the gate function over them. It emits a single-cycle output pulse when the gate result changes, at most once per logic step. `out` drives the `in` of the downstream gate-output stage (normal or faulty).

## Interface
Parameters:
- `LAMP_N`, 4: number of lamps, legal 1..8.
- `GATE_TYPE`, 0: gate function.
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR.
  - Other values: elaboration error.
- `LAMP_INIT`, 0: reset value of the lamp vector, `LAMP_N` bits.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `logic_reset` in 1: asynchronous, active-high; clears the whole block.
- `step_start` in 1: synchronous pulse marking a new logic step; re-arms the fire lock.
- `toggle` in `LAMP_N`: per-lamp toggle pulses. A bit high for one cycle flips that lamp once.
- `lamp_state` out `LAMP_N`: current lamp vector.
- `gate_state` out 1: last evaluated gate result.
- `out` in→out 1: registered single-cycle pulse on a gate result change while armed.
- `locked` out 1: high while the block has fired this step.
- `miss_cnt` out 8: suppressed-change counter. Present only with the macro; see Configuration.

## Operation
- Lamps: `lamp_state <= lamp_state ^ toggle` every cycle. Multiple bits in one cycle all apply.
- `eval` is combinational over `lamp_state`:
  - AND / NAND: all ones.
  - OR / NOR: any one.
  - XOR / XNOR: odd parity.
  - Inverting types complement the result.
- FSM states: ARMED, FIRE, LOCKED.
  - ARMED: if `eval != gate_state`, set `gate_state <= eval`, `out <= 1`, go to FIRE. Otherwise stay.
  - FIRE (one cycle): `out <= 0`, go to LOCKED.
  - LOCKED: `gate_state <= eval` silently; `out` stays 0. On `step_start`, go to ARMED.
- `locked` = state is FIRE or LOCKED.
- `step_start` in ARMED: no effect.
- `step_start` in FIRE: FIRE still completes its `out` pulse, then goes directly to ARMED (lock cleared).
- Simultaneous `step_start` and a changed `eval` in LOCKED: go to ARMED, update `gate_state` silently, no pulse that cycle.
- Toggle pairs that cancel within one cycle (same bit impossible; different bits giving an unchanged `eval`) produce no pulse.
- Reset values:
  - `lamp_state = LAMP_INIT`
  - `gate_state = f(LAMP_INIT)` (constant-folded, so no spurious fire after reset)
  - `out = 0`, `locked = 0`, state ARMED, `miss_cnt = 0`
- `logic_reset` mid-pulse forces `out` to 0 immediately (asynchronous).

## Timing
- Latency: `toggle` high in cycle t → `lamp_state` updated after edge t+1 → `out` high for cycle t+2 only.
- `gate_state` changes on the same edge that raises `out`.
- At most one `out` pulse between consecutive `step_start` pulses, plus the first step after reset.
- Throughput: the lamp register accepts toggles every cycle, including in FIRE and LOCKED.

## Configuration
- `GATE_LAMP_MISS_CNT_EN` defined:
  - `miss_cnt` port exists.
  - Increments by 1 on each cycle in FIRE or LOCKED where `eval != gate_state`.
  - Saturates at 255.
  - Cleared only by `logic_reset`.
- Not defined: port and counter absent; all other behaviour identical.

## Structure
- Shared package `gate_pkg`:
  - gate-type enum (AND..XNOR, 3 bits)
  - FSM state enum
  - `MAX_LAMP_N = 8`
  - function `gate_eval(type, vec, n)`, also used for the reset constant
- One sub-module `gate_lamp_bank`: toggle register with async reset to `LAMP_INIT`.
- FSM and counter live in the top.

## Test plan
- AND, `LAMP_N=2`, `LAMP_INIT=0`; toggle=01 at t=2, toggle=10 at t=5 → `out` high only at t=7, `gate_state` 1, `locked` 1.
- XOR, `LAMP_N=3`; toggle=001 at t=2, toggle=010 at t=3 (no `step_start`) → one pulse at t=4; `gate_state` ends 0; with macro, `miss_cnt`=1.
- Same as previous, then `step_start` at t=10 and toggle=100 at t=11 → second pulse at t=13.
- NOR, `LAMP_INIT=0`; reset release → `gate_state`=1, no pulse for 20 idle cycles.
- Reset mid-pulse: toggle=0001 at t=2 (OR), `logic_reset` asserted mid-cycle t=4 → `out` drops at once; `lamp_state`=`LAMP_INIT`; FSM ARMED.
- Saturation (macro defined): lock the block, then alternate toggle=1 for 300 cycles → `miss_cnt`=255 and holds.
